// File: rtl/ex_pkg.sv
// ex_pkg: shared constants for the MIPS execute stage.
//   - Bus widths (REGBUS, REGADDRBUS, ALUOPBUS).
//   - ALUOP_* operation codes as delivered by ID/EX.
//   - DIVSTATE_* encodings for the divider FSM.
//   - abs32(): magnitude of a 32-bit operand, optionally treated as signed.
// Build option: EX_DIV_EN (see ex.sv) selects whether DIV/DIVU exist.
package ex_pkg;

   localparam int REGBUS     = 32;
   localparam int REGADDRBUS = 5;
   localparam int ALUOPBUS   = 6;

   localparam logic [ALUOPBUS-1:0] ALUOP_NOP   = 6'd0;
   localparam logic [ALUOPBUS-1:0] ALUOP_AND   = 6'd1;
   localparam logic [ALUOPBUS-1:0] ALUOP_OR    = 6'd2;
   localparam logic [ALUOPBUS-1:0] ALUOP_XOR   = 6'd3;
   localparam logic [ALUOPBUS-1:0] ALUOP_NOR   = 6'd4;
   localparam logic [ALUOPBUS-1:0] ALUOP_ADDU  = 6'd5;
   localparam logic [ALUOPBUS-1:0] ALUOP_SUBU  = 6'd6;
   localparam logic [ALUOPBUS-1:0] ALUOP_SLT   = 6'd7;
   localparam logic [ALUOPBUS-1:0] ALUOP_SLTU  = 6'd8;
   localparam logic [ALUOPBUS-1:0] ALUOP_SLL   = 6'd9;
   localparam logic [ALUOPBUS-1:0] ALUOP_SRL   = 6'd10;
   localparam logic [ALUOPBUS-1:0] ALUOP_SRA   = 6'd11;
   localparam logic [ALUOPBUS-1:0] ALUOP_MFHI  = 6'd12;
   localparam logic [ALUOPBUS-1:0] ALUOP_MFLO  = 6'd13;
   localparam logic [ALUOPBUS-1:0] ALUOP_MTHI  = 6'd14;
   localparam logic [ALUOPBUS-1:0] ALUOP_MTLO  = 6'd15;
   localparam logic [ALUOPBUS-1:0] ALUOP_MULT  = 6'd16;
   localparam logic [ALUOPBUS-1:0] ALUOP_MULTU = 6'd17;
   localparam logic [ALUOPBUS-1:0] ALUOP_DIV   = 6'd18;
   localparam logic [ALUOPBUS-1:0] ALUOP_DIVU  = 6'd19;

   typedef enum logic [1:0] {
      DIVSTATE_IDLE = 2'd0,
      DIVSTATE_BUSY = 2'd1,
      DIVSTATE_DONE = 2'd2
   } divstate_e;

   function automatic logic [REGBUS-1:0] abs32(input logic [REGBUS-1:0] v,
                                               input logic              is_signed);
      return (is_signed && v[REGBUS-1]) ? -v : v;
   endfunction

endpackage

// File: rtl/ex_div.sv
// div: multi-cycle restoring divider for DIV/DIVU.
//   clk, rst        : clock, asynchronous active-high reset
//   start           : a divide op is present in EX this cycle
//   signed_div      : 1 = DIV (signed), 0 = DIVU
//   opdata1/opdata2 : dividend / divisor, latched when leaving IDLE
//   busy            : hold request (start seen in IDLE, or iterating)
//   result_hi/lo    : remainder / quotient, meaningful while ready
//   ready           : result cycle (DONE)
// Divide-by-zero skips iteration: HI = raw dividend, LO = all ones.
module div
   import ex_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              signed_div,
   input  logic [REGBUS-1:0] opdata1,
   input  logic [REGBUS-1:0] opdata2,
   output logic              busy,
   output logic [REGBUS-1:0] result_hi,
   output logic [REGBUS-1:0] result_lo,
   output logic              ready
);

   divstate_e         state, state_nxt;
   logic [4:0]        count;
   logic [REGBUS-1:0] dvd;    // dividend magnitude, shifted left; fills with quotient bits
   logic [REGBUS-1:0] dvs;    // divisor magnitude
   logic [REGBUS-1:0] rem;    // partial remainder
   logic              neg_q;
   logic              neg_r;
   logic [REGBUS:0]   trial;
   logic              take;

   // Bring in the next dividend bit; subtract if the divisor fits.
   assign trial = {rem, dvd[REGBUS-1]};
   assign take  = (trial >= {1'b0, dvs});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= DIVSTATE_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         DIVSTATE_IDLE: if (start) state_nxt = (opdata2 == '0) ? DIVSTATE_DONE : DIVSTATE_BUSY;
         DIVSTATE_BUSY: if (count == 5'd31) state_nxt = DIVSTATE_DONE;
         DIVSTATE_DONE: state_nxt = DIVSTATE_IDLE;
         default:       state_nxt = DIVSTATE_IDLE;
      endcase
   end

   always_comb begin
      busy      = 1'b0;
      ready     = 1'b0;
      result_lo = neg_q ? -dvd : dvd;
      result_hi = neg_r ? -rem : rem;
      case (state)
         DIVSTATE_IDLE: busy  = start;
         DIVSTATE_BUSY: busy  = 1'b1;
         DIVSTATE_DONE: ready = 1'b1;
         default:       busy  = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
         dvd   <= '0;
         dvs   <= '0;
         rem   <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
      end else if (state == DIVSTATE_IDLE && start) begin
         count <= '0;
         if (opdata2 == '0) begin
            // Preload the fixed divide-by-zero result; no sign fix-up.
            rem   <= opdata1;
            dvd   <= '1;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
         end else begin
            rem   <= '0;
            dvd   <= abs32(opdata1, signed_div);
            dvs   <= abs32(opdata2, signed_div);
            neg_q <= signed_div & (opdata1[REGBUS-1] ^ opdata2[REGBUS-1]);
            neg_r <= signed_div & opdata1[REGBUS-1];
         end
      end else if (state == DIVSTATE_BUSY) begin
         count <= count + 5'd1;
         if (take) begin
            rem <= trial[REGBUS-1:0] - dvs;
            dvd <= {dvd[REGBUS-2:0], 1'b1};
         end else begin
            rem <= trial[REGBUS-1:0];
            dvd <= {dvd[REGBUS-2:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/ex.sv
// ex: execute stage between ID/EX and EX/MEM.
//   clk, rst                 : clock, asynchronous active-high reset
//   aluop_i, reg1_i, reg2_i  : operation and forwarded GPR operands
//   wd_i, wreg_i             : destination register and its write enable
//   hi_i, lo_i               : architectural HI/LO
//   mem_*_i, wb_*_i          : HI/LO forwards (MEM beats WB beats architectural)
//   ex_wd/ex_wreg/ex_wdata   : GPR write-back fields to EX/MEM
//   ex_hi/ex_lo/ex_whilo     : HI/LO write fields to EX/MEM
//   stallreq                 : hold request while a divide is in flight
// Build option: define EX_DIV_EN to build the divider; otherwise DIV/DIVU
// are NOPs and stallreq is constant 0.
// Shifts take the amount from reg1_i[4:0] and shift reg2_i.
module ex
   import ex_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ALUOPBUS-1:0]   aluop_i,
   input  logic [REGBUS-1:0]     reg1_i,
   input  logic [REGBUS-1:0]     reg2_i,
   input  logic [REGADDRBUS-1:0] wd_i,
   input  logic                  wreg_i,
   input  logic [REGBUS-1:0]     hi_i,
   input  logic [REGBUS-1:0]     lo_i,
   input  logic                  mem_whilo_i,
   input  logic [REGBUS-1:0]     mem_hi_i,
   input  logic [REGBUS-1:0]     mem_lo_i,
   input  logic                  wb_whilo_i,
   input  logic [REGBUS-1:0]     wb_hi_i,
   input  logic [REGBUS-1:0]     wb_lo_i,
   output logic [REGADDRBUS-1:0] ex_wd,
   output logic                  ex_wreg,
   output logic [REGBUS-1:0]     ex_wdata,
   output logic [REGBUS-1:0]     ex_hi,
   output logic [REGBUS-1:0]     ex_lo,
   output logic                  ex_whilo,
   output logic                  stallreq
);

   logic [REGBUS-1:0]          hi_fwd, lo_fwd;
   logic [4:0]                 shamt;
   logic signed [2*REGBUS-1:0] prod_s;
   logic [2*REGBUS-1:0]        prod_u;
   logic                       div_busy;

   assign hi_fwd = mem_whilo_i ? mem_hi_i : (wb_whilo_i ? wb_hi_i : hi_i);
   assign lo_fwd = mem_whilo_i ? mem_lo_i : (wb_whilo_i ? wb_lo_i : lo_i);
   assign shamt  = reg1_i[4:0];
   assign prod_s = $signed(reg1_i) * $signed(reg2_i);
   assign prod_u = {{REGBUS{1'b0}}, reg1_i} * {{REGBUS{1'b0}}, reg2_i};

`ifdef EX_DIV_EN
   logic              div_start;
   logic              div_ready;
   logic [REGBUS-1:0] div_hi, div_lo;

   assign div_start = (aluop_i == ALUOP_DIV) || (aluop_i == ALUOP_DIVU);

   div u_div (
      .clk        (clk),
      .rst        (rst),
      .start      (div_start),
      .signed_div (aluop_i == ALUOP_DIV),
      .opdata1    (reg1_i),
      .opdata2    (reg2_i),
      .busy       (div_busy),
      .result_hi  (div_hi),
      .result_lo  (div_lo),
      .ready      (div_ready)
   );
`else
   logic unused_clk;
   assign unused_clk = clk;
   assign div_busy   = 1'b0;
`endif

   assign stallreq = rst ? 1'b0 : div_busy;

   always_comb begin
      ex_wd    = wd_i;
      ex_wreg  = 1'b0;
      ex_wdata = '0;
      ex_hi    = '0;
      ex_lo    = '0;
      ex_whilo = 1'b0;
      case (aluop_i)
         ALUOP_AND:  begin ex_wreg = wreg_i; ex_wdata = reg1_i & reg2_i; end
         ALUOP_OR:   begin ex_wreg = wreg_i; ex_wdata = reg1_i | reg2_i; end
         ALUOP_XOR:  begin ex_wreg = wreg_i; ex_wdata = reg1_i ^ reg2_i; end
         ALUOP_NOR:  begin ex_wreg = wreg_i; ex_wdata = ~(reg1_i | reg2_i); end
         ALUOP_ADDU: begin ex_wreg = wreg_i; ex_wdata = reg1_i + reg2_i; end
         ALUOP_SUBU: begin ex_wreg = wreg_i; ex_wdata = reg1_i - reg2_i; end
         ALUOP_SLT:  begin
            ex_wreg  = wreg_i;
            ex_wdata = {{(REGBUS-1){1'b0}}, ($signed(reg1_i) < $signed(reg2_i))};
         end
         ALUOP_SLTU: begin
            ex_wreg  = wreg_i;
            ex_wdata = {{(REGBUS-1){1'b0}}, (reg1_i < reg2_i)};
         end
         ALUOP_SLL:  begin ex_wreg = wreg_i; ex_wdata = reg2_i << shamt; end
         ALUOP_SRL:  begin ex_wreg = wreg_i; ex_wdata = reg2_i >> shamt; end
         ALUOP_SRA:  begin ex_wreg = wreg_i; ex_wdata = $unsigned($signed(reg2_i) >>> shamt); end
         ALUOP_MFHI: begin ex_wreg = wreg_i; ex_wdata = hi_fwd; end
         ALUOP_MFLO: begin ex_wreg = wreg_i; ex_wdata = lo_fwd; end
         ALUOP_MTHI: begin ex_whilo = 1'b1; ex_hi = reg1_i; ex_lo = lo_fwd; end
         ALUOP_MTLO: begin ex_whilo = 1'b1; ex_hi = hi_fwd; ex_lo = reg1_i; end
         ALUOP_MULT: begin
            ex_whilo = 1'b1;
            ex_hi    = prod_s[2*REGBUS-1:REGBUS];
            ex_lo    = prod_s[REGBUS-1:0];
         end
         ALUOP_MULTU: begin
            ex_whilo = 1'b1;
            ex_hi    = prod_u[2*REGBUS-1:REGBUS];
            ex_lo    = prod_u[REGBUS-1:0];
         end
`ifdef EX_DIV_EN
         ALUOP_DIV, ALUOP_DIVU: begin
            // HI/LO are written only in the result cycle; never a GPR.
            if (div_ready) begin
               ex_whilo = 1'b1;
               ex_hi    = div_hi;
               ex_lo    = div_lo;
            end
         end
`endif
         default: ex_wreg = 1'b0;
      endcase
      if (rst) begin
         ex_wd    = '0;
         ex_wreg  = 1'b0;
         ex_wdata = '0;
         ex_hi    = '0;
         ex_lo    = '0;
         ex_whilo = 1'b0;
      end
   end

endmodule

// File: tb/tb_ex.sv
// tb_ex: randomized bench for ex with a behavioural model checked on every
// falling edge, plus literal expectations for the directed cases.
module tb_ex;
   import ex_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  aluop = ALUOP_NOP;
   logic [31:0] reg1 = '0, reg2 = '0;
   logic [4:0]  wd = '0;
   logic        wreg = 1'b0;
   logic [31:0] hi = '0, lo = '0;
   logic        mem_whilo = 1'b0, wb_whilo = 1'b0;
   logic [31:0] mem_hi = '0, mem_lo = '0, wb_hi = '0, wb_lo = '0;
   logic [4:0]  ex_wd;
   logic        ex_wreg, ex_whilo, stallreq;
   logic [31:0] ex_wdata, ex_hi, ex_lo;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ex dut (
      .clk(clk), .rst(rst), .aluop_i(aluop), .reg1_i(reg1), .reg2_i(reg2),
      .wd_i(wd), .wreg_i(wreg), .hi_i(hi), .lo_i(lo),
      .mem_whilo_i(mem_whilo), .mem_hi_i(mem_hi), .mem_lo_i(mem_lo),
      .wb_whilo_i(wb_whilo), .wb_hi_i(wb_hi), .wb_lo_i(wb_lo),
      .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
      .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_whilo(ex_whilo), .stallreq(stallreq)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      logic [31:0] wdata, hi, lo;
      logic        wreg, whilo, stall;
   } exp_t;

   function automatic exp_t model_comb(input logic [5:0] op, input logic [31:0] a, b,
                                       input logic we, input logic [31:0] hf, lf);
      exp_t e;
      longint      ps;
      longint unsigned pu;
      int unsigned sh;
      e = '{wdata: 32'h0, hi: 32'h0, lo: 32'h0, wreg: 1'b0, whilo: 1'b0, stall: 1'b0};
      sh = a % 32;
      case (op)
         ALUOP_AND:  begin e.wreg = we; e.wdata = a & b; end
         ALUOP_OR:   begin e.wreg = we; e.wdata = a | b; end
         ALUOP_XOR:  begin e.wreg = we; e.wdata = a ^ b; end
         ALUOP_NOR:  begin e.wreg = we; e.wdata = ~(a | b); end
         ALUOP_ADDU: begin e.wreg = we; e.wdata = 32'(longint'(a) + longint'(b)); end
         ALUOP_SUBU: begin e.wreg = we; e.wdata = 32'(longint'(a) - longint'(b)); end
         ALUOP_SLT:  begin e.wreg = we; e.wdata = (longint'($signed(a)) < longint'($signed(b))) ? 1 : 0; end
         ALUOP_SLTU: begin e.wreg = we; e.wdata = (longint'(a) < longint'(b)) ? 1 : 0; end
         ALUOP_SLL:  begin e.wreg = we; e.wdata = 32'(longint'(b) * (longint'(1) << sh)); end
         ALUOP_SRL:  begin e.wreg = we; e.wdata = 32'(longint'(b) / (longint'(1) << sh)); end
         ALUOP_SRA:  begin
            e.wreg  = we;
            e.wdata = (b / (32'd1 << sh)) | (b[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
         end
         ALUOP_MFHI: begin e.wreg = we; e.wdata = hf; end
         ALUOP_MFLO: begin e.wreg = we; e.wdata = lf; end
         ALUOP_MTHI: begin e.whilo = 1'b1; e.hi = a; e.lo = lf; end
         ALUOP_MTLO: begin e.whilo = 1'b1; e.hi = hf; e.lo = a; end
         ALUOP_MULT: begin
            ps = longint'($signed(a)) * longint'($signed(b));
            e.whilo = 1'b1; e.hi = ps[63:32]; e.lo = ps[31:0];
         end
         ALUOP_MULTU: begin
            pu = longint'(a) * longint'(b);
            e.whilo = 1'b1; e.hi = pu[63:32]; e.lo = pu[31:0];
         end
         default: e.wreg = 1'b0;
      endcase
      return e;
   endfunction

   task automatic model_div(input logic is_signed, input logic [31:0] a, b,
                            output logic [31:0] rh, output logic [31:0] rl);
      longint q, r;
      if (b == 32'h0) begin
         rh = a; rl = 32'hFFFF_FFFF;
      end else begin
         if (is_signed) begin
            q = longint'($signed(a)) / longint'($signed(b));
            r = longint'($signed(a)) % longint'($signed(b));
         end else begin
            q = longint'(a) / longint'(b);
            r = longint'(a) % longint'(b);
         end
         rl = q[31:0]; rh = r[31:0];
      end
   endtask

   // Divide tracking: cycles since issue and the total latency to the result.
   int          div_k = -1;
   int          div_lat = 0;
   logic [31:0] div_hi = '0, div_lo = '0;

   always @(negedge clk) begin
      exp_t        e;
      logic [31:0] hf, lf;
      e = '{wdata: 32'h0, hi: 32'h0, lo: 32'h0, wreg: 1'b0, whilo: 1'b0, stall: 1'b0};
      hf = mem_whilo ? mem_hi : (wb_whilo ? wb_hi : hi);
      lf = mem_whilo ? mem_lo : (wb_whilo ? wb_lo : lo);
      if (rst) begin
         div_k = -1;
         check("rst_wd", 32'(ex_wd), 32'h0);
         check("rst_wdata", ex_wdata, 32'h0);
         check("rst_hi", ex_hi, 32'h0);
         check("rst_lo", ex_lo, 32'h0);
      end else if (div_k >= 0) begin
         div_k++;
         if (div_k < div_lat) e.stall = 1'b1;
         else begin
            e.whilo = 1'b1; e.hi = div_hi; e.lo = div_lo;
            div_k = -1;
         end
      end
`ifdef EX_DIV_EN
      else if (aluop == ALUOP_DIV || aluop == ALUOP_DIVU) begin
         model_div(aluop == ALUOP_DIV, reg1, reg2, div_hi, div_lo);
         div_lat = (reg2 == 32'h0) ? 1 : 33;
         div_k   = 0;
         e.stall = 1'b1;
      end
`endif
      else begin
         e = model_comb(aluop, reg1, reg2, wreg, hf, lf);
      end
      check("stallreq", 32'(stallreq), 32'(e.stall));
      check("ex_wreg", 32'(ex_wreg), 32'(e.wreg));
      check("ex_whilo", 32'(ex_whilo), 32'(e.whilo));
      if (e.wreg) begin
         check("ex_wd", 32'(ex_wd), 32'(wd));
         check("ex_wdata", ex_wdata, e.wdata);
      end
      if (e.whilo) begin
         check("ex_hi", ex_hi, e.hi);
         check("ex_lo", ex_lo, e.lo);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic apply(input logic [5:0] op, input logic [31:0] a, b);
      @(posedge clk); #1;
      aluop = op; reg1 = a; reg2 = b;
      wd = 5'($urandom_range(1, 31));
   endtask

   // Issue a divide and hold it; operands are scrambled while stalled.
   task automatic run_div(input logic [5:0] op, input logic [31:0] a, b,
                          output int stalls, output logic [31:0] rh, rl,
                          output logic rw);
      bit done = 0;
      apply(op, a, b);
      stalls = 0; rh = '0; rl = '0; rw = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (stallreq) begin
            stalls++;
            @(posedge clk); #1;
            reg1 = $urandom; reg2 = $urandom;
         end else begin
            rh = ex_hi; rl = ex_lo; rw = ex_whilo; done = 1;
         end
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL div_timeout actual=stalled expected=result within 40 cycles");
      end
   endtask

   function automatic logic [31:0] rnd32();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      int          st;
      logic [31:0] rh, rl;
      logic        rw;
      logic [5:0]  op;

      repeat (2) @(posedge clk);
      #2;
      check("reset_stallreq", 32'(stallreq), 32'h0);
      check("reset_whilo", 32'(ex_whilo), 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;

      wreg = 1'b1;
      apply(ALUOP_ADDU, 32'h7FFF_FFFF, 32'h1); #2;
      check("addu_wrap", ex_wdata, 32'h8000_0000);
      check("addu_wreg", 32'(ex_wreg), 32'h1);
      check("addu_stall", 32'(stallreq), 32'h0);

      hi = 32'd1; wb_hi = 32'd2; wb_whilo = 1'b1; mem_hi = 32'd3; mem_whilo = 1'b1;
      apply(ALUOP_MFHI, 32'h0, 32'h0); #2;
      check("fwd_mem", ex_wdata, 32'd3);
      apply(ALUOP_MFHI, 32'h0, 32'h0); mem_whilo = 1'b0; #2;
      check("fwd_wb", ex_wdata, 32'd2);
      apply(ALUOP_MFHI, 32'h0, 32'h0); wb_whilo = 1'b0; #2;
      check("fwd_arch", ex_wdata, 32'd1);

      apply(ALUOP_MULT, 32'hFFFF_FFFF, 32'h2); #2;
      check("mult_hi", ex_hi, 32'hFFFF_FFFF);
      check("mult_lo", ex_lo, 32'hFFFF_FFFE);
      apply(ALUOP_MULTU, 32'hFFFF_FFFF, 32'h2); #2;
      check("multu_hi", ex_hi, 32'h1);
      check("multu_lo", ex_lo, 32'hFFFF_FFFE);

      apply(ALUOP_SRA, 32'd4, 32'h8000_0000); #2;
      check("sra_fill", ex_wdata, 32'hF800_0000);

`ifdef EX_DIV_EN
      run_div(ALUOP_DIV, 32'hFFFF_FFF9, 32'd2, st, rh, rl, rw);
      check("div_stall_cycles", 32'(st), 32'd33);
      check("div_lo", rl, 32'hFFFF_FFFD);
      check("div_hi", rh, 32'hFFFF_FFFF);
      check("div_whilo", 32'(rw), 32'h1);

      run_div(ALUOP_DIVU, 32'd5, 32'd0, st, rh, rl, rw);
      check("dz_stall_cycles", 32'(st), 32'd1);
      check("dz_hi", rh, 32'd5);
      check("dz_lo", rl, 32'hFFFF_FFFF);

      run_div(ALUOP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, st, rh, rl, rw);
      check("minneg_lo", rl, 32'h8000_0000);
      check("minneg_hi", rh, 32'h0);

      // Back-to-back: second divide starts right after the first result.
      run_div(ALUOP_DIVU, 32'd9, 32'd4, st, rh, rl, rw);
      run_div(ALUOP_DIVU, 32'd1000, 32'd33, st, rh, rl, rw);
      check("b2b_stall_cycles", 32'(st), 32'd33);
      check("b2b_lo", rl, 32'd30);
      check("b2b_hi", rh, 32'd10);

      // Reset abort in the middle of iteration (count = 10).
      apply(ALUOP_DIVU, 32'd1000, 32'd3);
      repeat (11) @(posedge clk);
      #2; rst = 1'b1; #1;
      check("abort_stall", 32'(stallreq), 32'h0);
      check("abort_whilo", 32'(ex_whilo), 32'h0);
      check("abort_hi", ex_hi, 32'h0);
      check("abort_lo", ex_lo, 32'h0);
      check("abort_wdata", ex_wdata, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0; aluop = ALUOP_NOP;
      run_div(ALUOP_DIVU, 32'd100, 32'd7, st, rh, rl, rw);
      check("after_abort_stall_cycles", 32'(st), 32'd33);
      check("after_abort_lo", rl, 32'd14);
      check("after_abort_hi", rh, 32'd2);
`else
      run_div(ALUOP_DIV, 32'hFFFF_FFF9, 32'd2, st, rh, rl, rw);
      check("div_off_stall_cycles", 32'(st), 32'd0);
      check("div_off_whilo", 32'(rw), 32'h0);
`endif

      for (int i = 0; i < 400; i++) begin
         op = 6'($urandom_range(0, 23));
         if ($urandom_range(0, 9) == 0) op = 6'd63;
         hi = $urandom; lo = $urandom;
         mem_hi = $urandom; mem_lo = $urandom; wb_hi = $urandom; wb_lo = $urandom;
         mem_whilo = 1'($urandom_range(0, 1)); wb_whilo = 1'($urandom_range(0, 1));
         wreg = ($urandom_range(0, 3) != 0);
         if (op == ALUOP_DIV || op == ALUOP_DIVU)
            run_div(op, rnd32(), ($urandom_range(0, 3) == 0) ? 32'h0 : rnd32(), st, rh, rl, rw);
         else
            apply(op, rnd32(), rnd32());
      end

      apply(ALUOP_NOP, 32'h0, 32'h0);
      @(negedge clk);
      @(posedge clk); #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ex.md
# ex

Execute stage of the five-stage MIPS pipeline, between the ID/EX register and the EX/MEM register. Computes ALU, shift, move and multiply results combinationally and runs DIV/DIVU on a multi-cycle divider. Holds the pipeline with `stallreq` while a divide is in flight. Resolves HI/LO hazards by forwarding from the MEM and WB stages.

## Interface
Parameters: none. All widths come from `macro.v` (`REGBUS`=32, `REGADDRBUS`=5, `ALUOPBUS`=6).

Ports:
- `clk` in 1: pipeline clock.
- `rst` in 1: asynchronous, active-high reset.
- `aluop_i` in `ALUOPBUS`: operation code from ID/EX.
- `reg1_i`, `reg2_i` in 32: operands after GPR forwarding.
- `wd_i` in 5: destination register.
- `wreg_i` in 1: GPR write enable.
- `hi_i`, `lo_i` in 32: architectural HI/LO.
- `mem_whilo_i` in 1, `mem_hi_i` in 32, `mem_lo_i` in 32: HI/LO forward from the MEM stage.
- `wb_whilo_i` in 1, `wb_hi_i` in 32, `wb_lo_i` in 32: HI/LO forward from the WB stage.
- `ex_wd`, `ex_wreg`, `ex_wdata`: GPR write-back fields, to EX/MEM.
- `ex_hi`, `ex_lo` out 32, `ex_whilo` out 1: HI/LO write fields, to EX/MEM.
- `stallreq` out 1: pipeline-control hold request.

## Operation
- Ops: AND, OR, XOR, NOR, ADDU, SUBU, SLT (signed), SLTU, SLL, SRL, SRA, MFHI, MFLO, MTHI, MTLO, MULT, MULTU, DIV, DIVU, NOP.
- Shift operands:
  - Shift amount is `reg1_i[4:0]`; value is `reg2_i`.
  - SRA sign-fills from bit 31.
- ADDU/SUBU wrap modulo 2^32; no overflow trap.
- HI/LO source priority: MEM forward, then WB forward, then `hi_i`/`lo_i`.
- MFHI/MFLO write the forwarded value to `ex_wdata`; `ex_wreg` = `wreg_i`.
- MTHI/MTLO:
  - `ex_whilo`=1.
  - The selected half takes `reg1_i`; the other half passes through the forwarded value.
- MULT/MULTU:
  - Full 64-bit product, signed or unsigned.
  - `ex_hi`=product[63:32], `ex_lo`=product[31:0], `ex_whilo`=1.
- Divider FSM, states IDLE / BUSY / DONE:
  - IDLE with DIV/DIVU and divisor ≠ 0: latch operand magnitudes and the sign flag, set count=0, go to BUSY, assert `stallreq`.
  - IDLE with divisor = 0: go directly to DONE, `stallreq`=1 for this cycle only.
  - BUSY: one restoring-division bit per cycle, count 0..31. After the 32nd bit, go to DONE. `stallreq`=1 throughout.
  - DONE:
    - `stallreq`=0.
    - `ex_hi`=remainder, `ex_lo`=quotient, `ex_whilo`=1.
    - Next state is IDLE.
  - Signed result rules: quotient is negated when operand signs differ; remainder takes the dividend's sign. -2^31 / -1 gives LO=0x80000000, HI=0.
  - Divide-by-zero result: HI=dividend, LO=0xFFFFFFFF.
- DIV/DIVU never write a GPR (`ex_wreg`=0).
- While `rst`=1, all outputs are forced to 0; this is combinational.
- Reset values: FSM=IDLE, count=0, `stallreq`=0, `ex_wd`=0, `ex_wreg`=0, `ex_wdata`=0, `ex_hi`=0, `ex_lo`=0, `ex_whilo`=0.
- Unknown `aluop_i` behaves as NOP: all write enables 0.

## Timing
- All non-divide ops have zero-cycle combinational latency.
- DIV/DIVU issued in cycle N (divisor ≠ 0):
  - `stallreq` is high in cycles N..N+32.
  - Result is valid in cycle N+33 and captured by EX/MEM at the end of that cycle.
- Divisor = 0: result in cycle N+1.
- Back-to-back divides: the second starts from IDLE in the cycle after DONE.
- Operands are latched at start. Input changes during BUSY are ignored, since upstream is stalled.
- Asserting `rst` during BUSY aborts immediately to IDLE with outputs zero.

## Configuration
- `EX_DIV_EN` defined: divider FSM and sub-module are built as above.
- `EX_DIV_EN` undefined:
  - DIV/DIVU decode as NOP.
  - `stallreq` is tied 0; no divider state exists.

## Structure
- New `ALUOP_*` opcode constants and the `DIVSTATE_*` encodings go in `macro.v`.
- One sub-module, `div`: the FSM plus shift/subtract datapath.
  - Ports: clk, rst, start, signed_div, opdata1, opdata2.
  - Outputs: busy, result_hi, result_lo, ready.
- `ex` contains the op mux, HI/LO forwarding and the multiplier.

## Test plan
- ADDU 0x7FFFFFFF + 1 → `ex_wdata`=0x80000000, `ex_wreg`=1, `stallreq`=0.
- Forwarding: `hi_i`=1, `wb_hi_i`=2 with `wb_whilo_i`=1, `mem_hi_i`=3 with `mem_whilo_i`=1, then MFHI → `ex_wdata`=3.
- MULT 0xFFFFFFFF × 2 → `ex_hi`=0xFFFFFFFF, `ex_lo`=0xFFFFFFFE. The same operands under MULTU → `ex_hi`=1, `ex_lo`=0xFFFFFFFE.
- DIV -7 / 2 → `stallreq` high 33 cycles; in DONE, LO=0xFFFFFFFD, HI=0xFFFFFFFF, `ex_whilo`=1.
- DIVU 5 / 0 → `stallreq` high 1 cycle; HI=5, LO=0xFFFFFFFF.
- `rst` pulsed at BUSY count=10 → outputs 0 immediately. A subsequent DIVU 100 / 7 gives LO=14, HI=2 after the full 33-cycle stall.
